rs232_rx: RTL

RS-232 asynchronous serial receiver for the blaster_chip `rx232` pin, in the 48 MHz `clk` domain. It synchronises the line and recovers 8N1 frames with a 3-sample majority vote at mid-bit. Received bytes are buffered in a 4-entry FIFO and presented on a valid/ready stream to the command logic. It is the receiving counterpart of the board's `tx232` path.

---
 rtl/rs232_pkg.sv | 21 ++
 rtl/rs232_rx_fifo.sv | 60 ++++++
 rtl/rs232_rx.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/rs232_pkg.sv
// rs232_pkg: shared types and helpers for the RS-232 receive path.
//   rx_state_t        receiver FSM states
//   RS232_DIV_115200  clk cycles per bit at 48 MHz / 115200 baud
//   maj3              3-input majority vote
package rs232_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam int unsigned RS232_DIV_115200 = 417;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo: synchronous receive byte FIFO with overrun detection.
//   clk, reset_n  clock, synchronous active-low reset
//   push          byte offered by the receiver (push_data)
//   rx_ready      consumer ready; pop happens on rx_valid && rx_ready
//   rx_data       head entry (combinational read of registered head pointer)
//   rx_valid      FIFO not empty
//   overrun       one-cycle pulse when a push was dropped because full
module rs232_rx_fifo #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       overrun
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] head;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          full;
  logic          pop;
  logic          wr;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign rx_valid = (count != '0);
  assign pop      = rx_valid && rx_ready;
  // A full FIFO still accepts the push when the head leaves in the same cycle.
  assign wr       = push && (!full || pop);
  assign rx_data  = mem[head];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head    <= '0;
      tail    <= '0;
      count   <= '0;
      overrun <= 1'b0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && !wr;
      if (wr) begin
        mem[tail] <= push_data;
        tail      <= tail + 1'b1;
      end
      if (pop) head <= head + 1'b1;
      case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rs232_rx.sv
// rs232_rx: RS-232 8N1 receiver with 3-sample mid-bit majority vote and a
// small receive FIFO presented as a valid/ready stream.
//   clk, reset_n        clock, synchronous active-low reset
//   rx                  asynchronous serial line, idles high
//   rx_data, rx_valid   FIFO head byte / FIFO not empty
//   rx_ready            consumer accepts head when rx_valid && rx_ready
//   frame_err           pulse: stop bit low, byte discarded
//   break_det           pulse: data and stop all low
//   overrun             pulse: good byte dropped, FIFO full
//   busy                receiver not in IDLE
module rs232_rx
  import rs232_pkg::*;
#(
  parameter int unsigned DIV        = RS232_DIV_115200,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       break_det,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] MID_LO = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] MID    = CW'(DIV / 2);
  localparam logic [CW-1:0] MID_HI = CW'(DIV / 2 + 1);
  localparam logic [CW-1:0] LAST   = CW'(DIV - 1);

  rx_state_t     state, state_n;
  logic [1:0]    sync;
  logic          rxs;
  logic          rxs_d;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [1:0]    smp;
  logic [7:0]    shreg, shreg_n;
  logic          decide;
  logic          maj;
  logic          push;
  logic          ferr_n;
  logic          brk_n;

  assign rxs    = sync[1];
  assign decide = (cnt == MID_HI);
  // The third vote is the live sample taken on the deciding cycle.
  assign maj    = maj3(smp[0], smp[1], rxs);
  assign busy   = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync      <= 2'b11;
      rxs_d     <= 1'b1;
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      smp       <= 2'b11;
      shreg     <= '0;
      frame_err <= 1'b0;
      break_det <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      rxs_d     <= rxs;
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_idx_n;
      shreg     <= shreg_n;
      frame_err <= ferr_n;
      break_det <= brk_n;
      if (cnt == MID_LO) smp[0] <= rxs;
      if (cnt == MID)    smp[1] <= rxs;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    bit_idx_n = bit_idx;
    shreg_n   = shreg;
    push      = 1'b0;
    ferr_n    = 1'b0;
    brk_n     = 1'b0;
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (rxs_d && !rxs) state_n = START;
      end
      START: begin
        if (decide && maj) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == LAST) begin
          state_n   = DATA;
          cnt_n     = '0;
          bit_idx_n = '0;
        end
      end
      DATA: begin
        if (decide) shreg_n = {maj, shreg[7:1]};
        if (cnt == LAST) begin
          cnt_n = '0;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_idx_n = bit_idx + 1'b1;
        end
      end
      STOP: begin
        // Leave at the decision point so a back-to-back start edge is seen.
        if (decide) begin
          cnt_n = '0;
          if (maj) begin
            push    = 1'b1;
            state_n = IDLE;
          end else begin
            state_n = WAIT_HIGH;
            if (shreg == 8'h00) brk_n  = 1'b1;
            else                ferr_n = 1'b1;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_n = '0;
        if (rxs) state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  rs232_rx_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .push_data(shreg),
    .rx_ready (rx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .overrun  (overrun)
  );

endmodule
